m_ext_ctrl: RTL and testbench

Sequencing controller for the RV32M extension, sitting between the execute stage and the divider wrapper. It accepts one M-type instruction at a time from the execute stage and stalls the pipeline while the instruction runs. Multiplies (funct3 000–011) run on an internal radix-2 shift-add multiplier. Divides and remainders (funct3 100–111) are issued to the downstream divider wrapper through its start/done handshake, and the returned result is registered. The block presents a single registered result with a one-cycle valid pulse to writeback.

---
 rtl/m_ext_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_m_ext_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/m_ext_ctrl.sv
`timescale 1ns/1ps
// RV32M sequencing controller: shift-add multiplier for MUL*, start/done
// handshake to an external divider for DIV*/REM*, single registered result.
module m_ext_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [2:0]      i_f3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_stall,
  output logic [XLEN-1:0] o_res,
  output logic            o_res_valid,
  output logic            o_div_start,
  output logic [2:0]      o_div_f3,
  output logic [XLEN-1:0] o_div_rs1,
  output logic [XLEN-1:0] o_div_rs2,
  input  logic [XLEN-1:0] i_div_res,
  input  logic            i_div_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MUL    = 3'd1,
    S_MFIX   = 3'd2,
    S_DSTART = 3'd3,
    S_DBLANK = 3'd4,
    S_DWAIT  = 3'd5,
    S_RESP   = 3'd6
  } state_e;

  localparam logic [XLEN-1:0]   ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_2X = {{(2*XLEN-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [XLEN-1:0]     res_q, res_d;
  logic                res_valid_q, res_valid_d;
  logic                div_start_q, div_start_d;
  logic [2:0]          f3_q, f3_d;
  logic [XLEN-1:0]     rs1_q, rs1_d;
  logic [XLEN-1:0]     rs2_q, rs2_d;
  logic [XLEN-1:0]     mcand_q, mcand_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                neg_q, neg_d;
  logic [4:0]          cnt_q, cnt_d;

  logic                accept_s;
  logic                sgn1_s, sgn2_s;
  logic [XLEN-1:0]     mag1_s, mag2_s;
  logic [XLEN:0]       add_s;
  logic [2*XLEN-1:0]   prod_s;

  assign accept_s    = (state_q == S_IDLE) & i_valid & ~res_valid_q;
  assign o_stall     = i_valid & ~res_valid_q;
  assign o_res       = res_q;
  assign o_res_valid = res_valid_q;
  assign o_div_start = div_start_q;
  assign o_div_f3    = f3_q;
  assign o_div_rs1   = rs1_q;
  assign o_div_rs2   = rs2_q;

  // rs1 is signed for MULH/MULHSU, rs2 only for MULH; 0x80000000 needs no special case
  assign sgn1_s = ((i_f3 == 3'b001) | (i_f3 == 3'b010)) & i_rs1[XLEN-1];
  assign sgn2_s = (i_f3 == 3'b001) & i_rs2[XLEN-1];
  assign mag1_s = sgn1_s ? (~i_rs1 + ONE_X) : i_rs1;
  assign mag2_s = sgn2_s ? (~i_rs2 + ONE_X) : i_rs2;
  assign add_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? mcand_q : {XLEN{1'b0}})};
  assign prod_s = neg_q ? (~acc_q + ONE_2X) : acc_q;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = i_f3[2] ? S_DSTART : S_MUL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (cnt_q == 5'd31) begin
          state_d = S_MFIX;
        end else begin
          state_d = S_MUL;
        end
      end
      S_MFIX:   state_d = S_RESP;
      S_DSTART: state_d = S_DBLANK;
      S_DBLANK: state_d = S_DWAIT;
      S_DWAIT: begin
        if (i_div_done) begin
          state_d = S_RESP;
        end else begin
          state_d = S_DWAIT;
        end
      end
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    res_d     = res_q;
    f3_d      = f3_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          f3_d    = i_f3;
          rs1_d   = i_rs1;
          rs2_d   = i_rs2;
          mcand_d = mag1_s;
          acc_d   = {{XLEN{1'b0}}, mag2_s};
          neg_d   = sgn1_s ^ sgn2_s;
          cnt_d   = 5'd0;
        end else begin
          cnt_d   = cnt_q;
        end
      end
      S_MUL: begin
        // conditional add into the high half, then shift the whole 65-bit value right
        acc_d = {add_s, acc_q[XLEN-1:1]};
        cnt_d = cnt_q + 5'd1;
      end
      S_MFIX: begin
        res_d = (f3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
      end
      S_DWAIT: begin
        if (i_div_done) begin
          res_d = i_div_res;
        end else begin
          res_d = res_q;
        end
      end
      default: begin
        res_d = res_q;
      end
    endcase
    res_valid_d = (state_d == S_RESP);
    div_start_d = (state_d == S_DSTART);
  end

  // Datapath and output registers
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      res_q       <= {XLEN{1'b0}};
      res_valid_q <= 1'b0;
      div_start_q <= 1'b0;
      f3_q        <= 3'd0;
      rs1_q       <= {XLEN{1'b0}};
      rs2_q       <= {XLEN{1'b0}};
      mcand_q     <= {XLEN{1'b0}};
      acc_q       <= {(2*XLEN){1'b0}};
      neg_q       <= 1'b0;
      cnt_q       <= 5'd0;
    end else begin
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      div_start_q <= div_start_d;
      f3_q        <= f3_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_m_ext_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for m_ext_ctrl with a behavioural divider that has
// configurable latency and a level done that lingers into the next operation.
module tb_m_ext_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [2:0]  f3 = 3'd0;
  logic [31:0] rs1 = 32'd0, rs2 = 32'd0;
  logic        stall, res_valid, div_start;
  logic [31:0] res, div_rs1, div_rs2;
  logic [2:0]  div_f3;
  logic [31:0] div_res = 32'd0;
  logic        div_done = 1'b0;

  m_ext_ctrl #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_f3(f3), .i_rs1(rs1), .i_rs2(rs2),
    .o_stall(stall), .o_res(res), .o_res_valid(res_valid), .o_div_start(div_start),
    .o_div_f3(div_f3), .o_div_rs1(div_rs1), .o_div_rs2(div_rs2),
    .i_div_res(div_res), .i_div_done(div_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] val;
    int          at;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Divider operand expectations and model controls
  int          div_lat = 2;
  int          div_hold = 1;
  int          dcnt = 0;
  bit          preset_req = 1'b0;
  logic [31:0] dpend = 32'd0;
  logic [31:0] exp_a = 32'd0, exp_b = 32'd0;
  logic [2:0]  exp_f3 = 3'd0;

  function automatic logic [31:0] div_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sq;
    sa = a;
    sb = b;
    case (f[1:0])
      2'b00: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        sq = sa / sb;
        return sq;
      end
      2'b01: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      2'b10: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        sq = sa % sb;
        return sq;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Behavioural divider: done rises div_lat cycles after start and stays high
  // until div_hold cycles into the next operation
  initial forever begin
    @(negedge clk);
    if (preset_req) begin
      div_done   = 1'b1;
      div_res    = 32'hDEADBEEF;
      preset_req = 1'b0;
    end else if (div_start === 1'b1) begin
      dcnt  = div_lat;
      dpend = div_ref(div_f3, div_rs1, div_rs2);
    end else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == div_lat - div_hold) div_done = 1'b0;
      if (dcnt == 0) begin
        div_done = 1'b1;
        div_res  = dpend;
        check("div_rs1_held", div_rs1, exp_a);
        check("div_rs2_held", div_rs2, exp_b);
        check("div_f3_held", {29'd0, div_f3}, {29'd0, exp_f3});
      end
    end
  end

  // Monitor: every strobe must match the oldest expectation in value and cycle
  initial forever begin
    @(negedge clk);
    if (res_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_strobe: got strobe at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_res"}, res, e.val);
        check({e.name, "_cycle"}, cyc, e.at);
      end
    end
  end

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat, input int hold);
    int   t, lat_total, stall_hi;
    bit   got;
    exp_t e;
    @(negedge clk);
    valid = 1'b1; f3 = f; rs1 = a; rs2 = b;
    div_lat = lat; div_hold = hold; exp_a = a; exp_b = b; exp_f3 = f;
    t = cyc;
    lat_total = f[2] ? lat + 2 : 34;
    e.val = exp; e.at = t + lat_total; e.name = name;
    sb_q.push_back(e);
    stall_hi = 0;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      #1;
      if (res_valid === 1'b1) begin
        got = 1'b1;
        check({name, "_stall_low"}, {31'd0, stall}, 32'd0);
      end else begin
        if (stall === 1'b1) stall_hi++;
        @(negedge clk);
      end
    end
    check({name, "_stall_cycles"}, stall_hi, lat_total);
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no strobe in 200 cycles, expected one at cycle %0d", name, t + lat_total);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_res"}, res, 32'd0);
    check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
    check({tag, "_div_start"}, {31'd0, div_start}, 32'd0);
    check({tag, "_div_f3"}, {29'd0, div_f3}, 32'd0);
    check({tag, "_div_rs1"}, div_rs1, 32'd0);
    check({tag, "_div_rs2"}, div_rs2, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    idle(2);

    run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0, 1);
    idle(1);
    run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 0, 1);
    idle(1);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1);
    idle(1);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 1);
    idle(1);
    run_op("div0",   3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 2, 1);
    idle(1);
    run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2, 1);
    idle(1);
    run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       33, 1);
    idle(1);
    run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        33, 1);
    idle(1);

    // done held high with a bogus value through DSTART/DBLANK
    preset_req = 1'b1;
    idle(2);
    run_op("stale",  3'b101, 32'd100,      32'd7,        32'd14,       9, 2);
    idle(1);

    // back-to-back: the divide is presented the cycle after the multiply strobe
    run_op("b2b_mul", 3'b000, 32'd3,  32'd5,        32'd15,       0, 1);
    run_op("b2b_div", 3'b100, 32'd20, 32'hFFFFFFFC, 32'hFFFFFFFB, 5, 1);
    idle(1);

    // reset at T+10 of a multiply abandons it without a strobe
    @(negedge clk);
    valid = 1'b1; f3 = 3'b000; rs1 = 32'd3; rs2 = 32'd9;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    rst = 1'b1;
    idle(40);

    run_op("post_mul", 3'b000, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 0, 1);
    idle(1);
    run_op("post_div", 3'b100, 32'd7,        32'd2, 32'd3,        3, 1);
    idle(3);

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test by time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
